// File: rtl/y86_pkg.sv
// ============================================================================
// y86_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the Y86 SEQ stage sequencer:
//   - state_t       : sequencer FSM states
//   - stat_t        : processor status codes (AOK/HLT/ADR/INS)
//   - ICODE_*       : Y86 instruction codes
//   - TIMER_W       : width of the handshake wait counter (holds 0..254)
//   - is_mem_icode  : true for instructions that access data memory
// ============================================================================
package y86_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_EXEC,
        S_MEM,
        S_MWAIT,
        S_WB,
        S_PCUPD,
        S_HALTED,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Wide enough for the largest supported timeout (255).
    localparam int TIMER_W = 8;

    // Instructions whose memory stage must wait for a data-memory handshake.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        case (ic)
            ICODE_RMMOVQ, ICODE_MRMOVQ,
            ICODE_CALL,   ICODE_RET,
            ICODE_PUSHQ,  ICODE_POPQ: is_mem_icode = 1'b1;
            default:                  is_mem_icode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_wait_timer.sv
// ============================================================================
// y86_wait_timer
// ----------------------------------------------------------------------------
// Counts consecutive cycles spent in a handshake wait state and flags the
// cycle in which the budget of MEM_TIMEOUT cycles is used up.
//
// Parameters:
//   MEM_TIMEOUT : number of waiting cycles allowed (1..255)
//
// Ports:
//   clk     in  : clock
//   rst     in  : synchronous active-high reset
//   waiting in  : sequencer is in FWAIT or MWAIT this cycle
//   timeout out : this is the MEM_TIMEOUT-th waiting cycle
//
// The counter holds the number of waiting cycles already completed, so it
// reads 0 in the first cycle of a wait and is held at 0 whenever the
// sequencer is not waiting, which clears it on every entry to a wait state.
// ============================================================================
module y86_wait_timer
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout
);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || !waiting) begin
            count <= '0;
        end else begin
            count <= count + TIMER_W'(1);
        end
    end

    // The sequencer leaves the wait state on this flag, so the counter never
    // runs past MEM_TIMEOUT-1.
    assign timeout = waiting && (count == TIMER_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/y86_stage_sequencer.sv
// ============================================================================
// y86_stage_sequencer
// ----------------------------------------------------------------------------
// Clocked stage sequencer for the Y86 SEQ core. Issues one-cycle enable
// strobes to the fetch, execute, memory, write-back and PC-update stages,
// waits on the fetch and data-memory handshakes with a bounded timeout and
// tracks the processor status.
//
// Parameters:
//   MEM_TIMEOUT : max waiting cycles on fetch_ack / dmem_ready (1..255)
//   CNT_W       : width of the performance counters
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : leave IDLE and begin fetching
//   fetch_ack                : fetch stage finished aligning/decoding
//   instr_valid, imem_err    : fetch status, sampled with fetch_ack
//   icode                    : instruction code, sampled with fetch_ack
//   dmem_ready, dmem_err     : data-memory completion and its status
//   fet, exec, mem,
//   write_back, pc_update    : registered one-cycle stage strobes
//   busy                     : sequencer is running an instruction
//   stat                     : 1 AOK, 2 HLT, 3 ADR, 4 INS
//   cycle_count, instr_count : performance counters
//
// Configuration:
//   Y86_SEQ_PERF_EN : when defined, cycle_count/instr_count are live
//                     counters; otherwise both read 0 and no counter flops
//                     are built.
//
// Every output is registered together with the state transition that
// produces it, so a strobe is high exactly while the FSM sits in the
// matching state and busy/stat change in the same cycle as the state.
// ============================================================================
module y86_stage_sequencer
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fetch_ack,
    input  logic             instr_valid,
    input  logic             imem_err,
    input  logic [3:0]       icode,
    input  logic             dmem_ready,
    input  logic             dmem_err,
    output logic             fet,
    output logic             exec,
    output logic             mem,
    output logic             write_back,
    output logic             pc_update,
    output logic             busy,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    stat_t      stat_q;
    logic [3:0] icode_q;
    logic       waiting;
    logic       timeout;

    assign waiting = (state == S_FWAIT) || (state == S_MWAIT);
    assign stat    = stat_q;

    y86_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .timeout (timeout)
    );

    // ------------------------------------------------------------------------
    // Sequencer FSM. Acks are examined before the timeout flag, so an ack in
    // the last allowed waiting cycle still completes the handshake.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            stat_q     <= STAT_AOK;
            icode_q    <= ICODE_HALT;
            busy       <= 1'b0;
            fet        <= 1'b0;
            exec       <= 1'b0;
            mem        <= 1'b0;
            write_back <= 1'b0;
            pc_update  <= 1'b0;
        end else begin
            // Strobes default low; only the transition into a stage raises one.
            fet        <= 1'b0;
            exec       <= 1'b0;
            mem        <= 1'b0;
            write_back <= 1'b0;
            pc_update  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        fet   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                S_FETCH: begin
                    state <= S_FWAIT;
                end

                S_FWAIT: begin
                    if (fetch_ack) begin
                        if (imem_err) begin
                            state  <= S_FAULT;
                            stat_q <= STAT_ADR;
                            busy   <= 1'b0;
                        end else if (!instr_valid) begin
                            state  <= S_FAULT;
                            stat_q <= STAT_INS;
                            busy   <= 1'b0;
                        end else begin
                            icode_q <= icode;
                            state   <= S_EXEC;
                            exec    <= 1'b1;
                        end
                    end else if (timeout) begin
                        state  <= S_FAULT;
                        stat_q <= STAT_ADR;
                        busy   <= 1'b0;
                    end
                end

                S_EXEC: begin
                    state <= S_MEM;
                    mem   <= 1'b1;
                end

                S_MEM: begin
                    if (is_mem_icode(icode_q)) begin
                        state <= S_MWAIT;
                    end else begin
                        state      <= S_WB;
                        write_back <= 1'b1;
                    end
                end

                S_MWAIT: begin
                    if (dmem_ready) begin
                        if (dmem_err) begin
                            state  <= S_FAULT;
                            stat_q <= STAT_ADR;
                            busy   <= 1'b0;
                        end else begin
                            state      <= S_WB;
                            write_back <= 1'b1;
                        end
                    end else if (timeout) begin
                        state  <= S_FAULT;
                        stat_q <= STAT_ADR;
                        busy   <= 1'b0;
                    end
                end

                S_WB: begin
                    state     <= S_PCUPD;
                    pc_update <= 1'b1;
                end

                S_PCUPD: begin
                    if (icode_q == ICODE_HALT) begin
                        state  <= S_HALTED;
                        stat_q <= STAT_HLT;
                        busy   <= 1'b0;
                    end else begin
                        state <= S_FETCH;
                        fet   <= 1'b1;
                    end
                end

                // Absorbing: only rst leaves these.
                S_HALTED, S_FAULT: begin
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters. Both wrap naturally at 2^CNT_W.
    // ------------------------------------------------------------------------
`ifdef Y86_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (busy) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            // Counts the halt instruction's PC-update cycle as well.
            if (state == S_PCUPD) begin
                instr_q <= instr_q + CNT_W'(1);
            end
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// ============================================================================
// tb_y86_stage_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench. Each scenario is expanded into a cycle-by-cycle
// schedule: inputs to drive and outputs expected, derived from the stage
// sequence of each instruction (fetch, ack wait, execute, memory, optional
// data wait, write-back, PC update) and the fault/halt rules. Inputs that
// should be ignored carry random noise. The schedule is then played against
// the DUT, with outputs sampled on the falling edge.
// ============================================================================
module tb_y86_stage_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 32;

`ifdef Y86_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam bit [2:0] AOK = 3'd1;
    localparam bit [2:0] HLT = 3'd2;
    localparam bit [2:0] ADR = 3'd3;
    localparam bit [2:0] INS = 3'd4;

    // Strobe vector order: {fet, exec, mem, write_back, pc_update}
    localparam bit [4:0] ST_NONE = 5'b00000;
    localparam bit [4:0] ST_FET  = 5'b10000;
    localparam bit [4:0] ST_EXE  = 5'b01000;
    localparam bit [4:0] ST_MEM  = 5'b00100;
    localparam bit [4:0] ST_WB   = 5'b00010;
    localparam bit [4:0] ST_PCU  = 5'b00001;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          fetch_ack;
    logic          instr_valid;
    logic          imem_err;
    logic [3:0]    icode;
    logic          dmem_ready;
    logic          dmem_err;
    logic          fet;
    logic          exec;
    logic          mem;
    logic          write_back;
    logic          pc_update;
    logic          busy;
    logic [2:0]    stat;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    y86_stage_sequencer #(
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fetch_ack   (fetch_ack),
        .instr_valid (instr_valid),
        .imem_err    (imem_err),
        .icode       (icode),
        .dmem_ready  (dmem_ready),
        .dmem_err    (dmem_err),
        .fet         (fet),
        .exec        (exec),
        .mem         (mem),
        .write_back  (write_back),
        .pc_update   (pc_update),
        .busy        (busy),
        .stat        (stat),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    // One cycle of the schedule: inputs to drive and outputs expected.
    typedef struct {
        bit       start;
        bit       fack;
        bit       ivalid;
        bit       ierr;
        bit [3:0] ic;
        bit       dready;
        bit       derr;
        bit       rst;
        bit       chk;
        bit [4:0] strb;
        bit       busy;
        bit [2:0] stat;
    } cyc_t;

    cyc_t sched[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;
    longint exp_cyc = 0;
    longint exp_ins = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_no, got, exp);
        end
    endtask

    // Random values on every input; callers pin the ones that matter.
    function automatic cyc_t noise();
        cyc_t c;
        c.start  = 1'($urandom);
        c.fack   = 1'($urandom);
        c.ivalid = 1'($urandom);
        c.ierr   = 1'($urandom);
        c.ic     = 4'($urandom);
        c.dready = 1'($urandom);
        c.derr   = 1'($urandom);
        c.rst    = 1'b0;
        c.chk    = 1'b0;
        c.strb   = ST_NONE;
        c.busy   = 1'b0;
        c.stat   = AOK;
        return c;
    endfunction

    task automatic push(input cyc_t c, input bit [4:0] strb, input bit bsy, input bit [2:0] st);
        c.strb = strb;
        c.busy = bsy;
        c.stat = st;
        c.chk  = 1'b1;
        sched.push_back(c);
    endtask

    // Reset, then one quiet idle cycle.
    task automatic begin_scn();
        cyc_t c;
        c = noise();
        c.rst   = 1'b1;
        c.start = 1'b0;
        sched.push_back(c);
        c = noise();
        c.start = 1'b0;
        push(c, ST_NONE, 1'b0, AOK);
    endtask

    task automatic start_cyc();
        cyc_t c;
        c = noise();
        c.start = 1'b1;
        push(c, ST_NONE, 1'b0, AOK);
    endtask

    // Cycles spent in a terminal or idle condition.
    task automatic tail(input bit [2:0] st, input bit allow_start, input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = noise();
            if (!allow_start) c.start = 1'b0;
            push(c, ST_NONE, 1'b0, st);
        end
    endtask

    // One instruction. fd/dd: waiting cycles before the ack (>= TMO means the
    // ack never comes). rst_mw: data-wait cycle index in which to reset (-1 none).
    task automatic add_instr(input bit [3:0] ic, input int fd, input bit ierr, input bit ivalid,
                             input int dd, input bit derr, input int rst_mw,
                             output bit stop, output bit [2:0] fstat);
        cyc_t c;
        int   n;
        stop  = 1'b0;
        fstat = AOK;

        c = noise();
        push(c, ST_FET, 1'b1, AOK);

        n = (fd < TMO) ? fd + 1 : TMO;
        for (int i = 0; i < n; i++) begin
            c = noise();
            c.fack = (i == fd);
            if (c.fack) begin
                c.ierr   = ierr;
                c.ivalid = ivalid;
                c.ic     = ic;
            end
            push(c, ST_NONE, 1'b1, AOK);
        end
        if (fd >= TMO || ierr) begin
            stop = 1'b1; fstat = ADR; return;
        end
        if (!ivalid) begin
            stop = 1'b1; fstat = INS; return;
        end

        c = noise();
        push(c, ST_EXE, 1'b1, AOK);
        c = noise();
        push(c, ST_MEM, 1'b1, AOK);

        if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            n = (dd < TMO) ? dd + 1 : TMO;
            for (int i = 0; i < n; i++) begin
                c = noise();
                c.dready = (i == dd);
                if (c.dready) c.derr = derr;
                if (i == rst_mw) begin
                    c.rst = 1'b1;
                    push(c, ST_NONE, 1'b1, AOK);
                    stop = 1'b1; fstat = AOK; return;
                end
                push(c, ST_NONE, 1'b1, AOK);
            end
            if (dd >= TMO || derr) begin
                stop = 1'b1; fstat = ADR; return;
            end
        end

        c = noise();
        push(c, ST_WB, 1'b1, AOK);
        c = noise();
        push(c, ST_PCU, 1'b1, AOK);
        if (ic == 4'h0) begin
            stop = 1'b1; fstat = HLT;
        end
    endtask

    // Play the schedule: check outputs of each cycle, then drive its inputs.
    task automatic play();
        cyc_t c;
        while (sched.size() > 0) begin
            c = sched.pop_front();
            @(negedge clk);
            cyc_no++;
            if (c.chk) begin
                check("strobes", {fet, exec, mem, write_back, pc_update}, c.strb);
                check("one_strobe", ($countones({fet, exec, mem, write_back, pc_update}) <= 1), 1);
                check("busy", busy, c.busy);
                check("stat", stat, c.stat);
                check("cycle_count", cycle_count, PERF ? exp_cyc : 0);
                check("instr_count", instr_count, PERF ? exp_ins : 0);
            end
            if (c.rst) begin
                exp_cyc = 0;
                exp_ins = 0;
            end else begin
                if (c.busy) exp_cyc = (exp_cyc + 1) % (64'd1 << CW);
                if (c.strb == ST_PCU) exp_ins = (exp_ins + 1) % (64'd1 << CW);
            end
            rst         = c.rst;
            start       = c.start;
            fetch_ack   = c.fack;
            instr_valid = c.ivalid;
            imem_err    = c.ierr;
            icode       = c.ic;
            dmem_ready  = c.dready;
            dmem_err    = c.derr;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_no);
        $fatal(1, "watchdog");
    end

    initial begin
        bit       stop;
        bit [2:0] fs;

        rst = 1'b1; start = 1'b0; fetch_ack = 1'b0; instr_valid = 1'b0;
        imem_err = 1'b0; icode = 4'h0; dmem_ready = 1'b0; dmem_err = 1'b0;

        // nop, mrmovq with data ready in the 3rd wait cycle, halt; then
        // start pulses and acks in HALTED are ignored.
        begin_scn(); start_cyc();
        add_instr(4'h1, 0, 0, 1, 0, 0, -1, stop, fs);
        add_instr(4'h5, 0, 0, 1, 2, 0, -1, stop, fs);
        add_instr(4'h0, 0, 0, 1, 0, 0, -1, stop, fs);
        tail(fs, 1, 8);
        play();

        // Illegal instruction.
        begin_scn(); start_cyc();
        add_instr(4'h6, 1, 0, 0, 0, 0, -1, stop, fs);
        tail(fs, 1, 5);
        play();

        // imem_err has priority over !instr_valid.
        begin_scn(); start_cyc();
        add_instr(4'h2, 0, 1, 0, 0, 0, -1, stop, fs);
        tail(fs, 1, 5);
        play();

        // Data-memory timeout.
        begin_scn(); start_cyc();
        add_instr(4'h4, 0, 0, 1, 99, 0, -1, stop, fs);
        tail(fs, 1, 5);
        play();

        // dmem_ready in the last allowed cycle wins over the timeout.
        begin_scn(); start_cyc();
        add_instr(4'h8, 0, 0, 1, TMO - 1, 0, -1, stop, fs);
        add_instr(4'h0, 0, 0, 1, 0, 0, -1, stop, fs);
        tail(fs, 1, 4);
        play();

        // Fetch timeout, then fetch_ack in the last allowed cycle.
        begin_scn(); start_cyc();
        add_instr(4'h3, 99, 0, 1, 0, 0, -1, stop, fs);
        tail(fs, 1, 4);
        play();
        begin_scn(); start_cyc();
        add_instr(4'h3, TMO - 1, 0, 1, 0, 0, -1, stop, fs);
        add_instr(4'h0, 0, 0, 1, 0, 0, -1, stop, fs);
        tail(fs, 1, 4);
        play();

        // Data-memory address error.
        begin_scn(); start_cyc();
        add_instr(4'h9, 0, 0, 1, 1, 1, -1, stop, fs);
        tail(fs, 1, 4);
        play();

        // Reset during a data wait, then a fresh run.
        begin_scn(); start_cyc();
        add_instr(4'h7, 0, 0, 1, 0, 0, -1, stop, fs);
        add_instr(4'hB, 0, 0, 1, 99, 0, 1, stop, fs);
        tail(AOK, 0, 3);
        start_cyc();
        add_instr(4'h1, 0, 0, 1, 0, 0, -1, stop, fs);
        add_instr(4'h0, 0, 0, 1, 0, 0, -1, stop, fs);
        tail(fs, 1, 4);
        play();

        // Random programs with occasional faults.
        for (int s = 0; s < 30; s++) begin
            begin_scn(); start_cyc();
            stop = 1'b0;
            fs   = AOK;
            for (int k = 0; k < 8 && !stop; k++) begin
                bit [3:0] ic;
                int       r;
                int       fd;
                int       dd;
                ic = (k == 7) ? 4'h0 : 4'($urandom_range(0, 11));
                r  = int'($urandom % 16);
                fd = ($urandom % 8 == 0) ? TMO : int'($urandom_range(0, TMO - 1));
                dd = ($urandom % 8 == 0) ? TMO : int'($urandom_range(0, TMO - 1));
                add_instr(ic, fd, (r == 0), (r != 1), dd, ($urandom % 12 == 0), -1, stop, fs);
            end
            tail(fs, 1, 4);
            play();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
